// File: rtl/disparity_stream_postproc.sv
// disparity_stream_postproc: post-processes the stereo matcher's disparity stream.
// It fills holes from the last good value in the row and tags each pixel with
// start-of-frame and end-of-line. A FIFO then presents the results on a
// valid/ready port with first-word fall-through.
// Optional feature: define MEDIAN3_EN to insert a causal 3-tap horizontal median
// between the fill stage and the FIFO. This adds one cycle of latency.
module disparity_stream_postproc #(
    parameter int          ROW_LEN    = 310,
    parameter int          NUM_ROWS   = 238,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [7:0]  HOLE_VAL   = 8'd0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    disp_in,
    input  logic                          disp_valid,
    output logic [7:0]                    m_data,
    output logic                          m_sof,
    output logic                          m_eol,
    output logic                          m_valid,
    input  logic                          m_ready,
    input  logic                          clr_ovf,
    output logic                          ovf_sticky,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (ROW_LEN  > 1) ? $clog2(ROW_LEN)  : 1;
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    // Position counters and the last-good register.
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    lg_q, lg_d;
    logic          lg_vld_q, lg_vld_d;
    logic [7:0]    fill_d;
    logic          col_last, row_last;

    // Stage A output register.
    logic          a_vld_q;
    logic [7:0]    a_data_q;
    logic          a_sof_q, a_eol_q, a_last_q;

    // Word that is pushed into the FIFO, taken from stage A or from the median stage.
    logic          p_vld, p_sof, p_eol, p_last;
    logic [7:0]    p_data;

    assign col_last = (col_q == CW'(ROW_LEN - 1));
    assign row_last = (row_q == RW'(NUM_ROWS - 1));

    // Fill decision and next position. Clearing lg_vld at row end keeps fills inside one row.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        fill_d   = HOLE_VAL;
        col_d    = col_q;
        row_d    = row_q;
        lg_d     = lg_q;
        lg_vld_d = lg_vld_q;
        if (disp_in != HOLE_VAL) begin
            fill_d   = disp_in;
            lg_d     = disp_in;
            lg_vld_d = 1'b1;
        end else if (lg_vld_q) begin
            fill_d = lg_q;
        end
        if (col_last) begin
            col_d    = '0;
            lg_vld_d = 1'b0;
            row_d    = row_last ? '0 : row_q + RW'(1);
        end else begin
            col_d = col_q + CW'(1);
        end
    end

    // Stage A registers: the counters update and the filled pixel is captured on each accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q    <= '0;
            row_q    <= '0;
            lg_q     <= '0;
            lg_vld_q <= 1'b0;
            a_vld_q  <= 1'b0;
            a_data_q <= '0;
            a_sof_q  <= 1'b0;
            a_eol_q  <= 1'b0;
            a_last_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
            a_vld_q <= disp_valid;
            if (disp_valid) begin
                col_q    <= col_d;
                row_q    <= row_d;
                lg_q     <= lg_d;
                lg_vld_q <= lg_vld_d;
                a_data_q <= fill_d;
                a_sof_q  <= (row_q == '0) && (col_q == '0);
                a_eol_q  <= col_last;
                a_last_q <= col_last && row_last;
            end
        end
    end

`ifdef MEDIAN3_EN
    logic          a_bol_q;
    logic [7:0]    h1_q, h2_q;
    logic [1:0]    hcnt_q;
    logic          md_vld_q, md_sof_q, md_eol_q, md_last_q;
    logic [7:0]    md_data_q;

    function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        logic [7:0] lo, hi, m;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        m  = (hi < c) ? hi : c;
        return (lo > m) ? lo : m;
    endfunction

    // Begin-of-line flag that travels alongside the stage A output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          a_bol_q <= 1'b0;
        else if (disp_valid) a_bol_q <= (col_q == '0);
    end

    // Median stage: cols 0 and 1 pass through; from col 2 on, the output is median(f[c-2], f[c-1], f[c]).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_q      <= '0;
            h2_q      <= '0;
            hcnt_q    <= '0;
            md_vld_q  <= 1'b0;
            md_data_q <= '0;
            md_sof_q  <= 1'b0;
            md_eol_q  <= 1'b0;
            md_last_q <= 1'b0;
        end else begin
            md_vld_q <= a_vld_q;
            if (a_vld_q) begin
                md_sof_q  <= a_sof_q;
                md_eol_q  <= a_eol_q;
                md_last_q <= a_last_q;
                h1_q      <= a_data_q;
                h2_q      <= h1_q;
                if (a_bol_q) begin
                    hcnt_q    <= 2'd1;
                    md_data_q <= a_data_q;
                end else if (hcnt_q != 2'd2) begin
                    hcnt_q    <= 2'd2;
                    md_data_q <= a_data_q;
                end else begin
                    md_data_q <= med3(h2_q, h1_q, a_data_q);
                end
            end
        end
    end

    assign p_vld  = md_vld_q;
    assign p_data = md_data_q;
    assign p_sof  = md_sof_q;
    assign p_eol  = md_eol_q;
    assign p_last = md_last_q;
`else
    assign p_vld  = a_vld_q;
    assign p_data = a_data_q;
    assign p_sof  = a_sof_q;
    assign p_eol  = a_eol_q;
    assign p_last = a_last_q;
`endif

    // Output FIFO holding {sof, eol, data} entries.
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          full, empty, pop, push_ok;
    logic [9:0]    head;

    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign empty   = (level_q == '0);
    assign pop     = !empty && m_ready;
    assign push_ok = p_vld && (!full || pop);
    assign head    = mem_q[rd_ptr_q];

    // Storage writes. The contents are qualified by level, so the array needs no reset.
    always_ff @(posedge clk) begin
        // NOTE: the memory array is not reset; stale entries are never visible while the FIFO is empty.
        if (push_ok) mem_q[wr_ptr_q] <= {p_sof, p_eol, p_data};
    end

    // Pointer, level and overflow tracking. When overflow and clear happen in the same cycle, overflow wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (p_vld && !push_ok) ovf_sticky <= 1'b1;
            else if (clr_ovf)      ovf_sticky <= 1'b0;
        end
    end

    assign m_valid    = !empty;
    assign m_data     = m_valid ? head[7:0] : 8'd0;
    assign m_eol      = m_valid & head[8];
    assign m_sof      = m_valid & head[9];
    assign fifo_level = level_q;
    assign frame_done = push_ok && p_last;

endmodule

// File: tb/tb_disparity_stream_postproc.sv
// Directed bench for disparity_stream_postproc, configured with a small frame (4x3) and a 16-entry FIFO.
module tb_disparity_stream_postproc;
    localparam int ROW_LEN = 4;
    localparam int NUM_ROWS = 3;
    localparam int DEPTH = 16;
`ifdef MEDIAN3_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] disp_in = '0;
    logic       disp_valid = 1'b0;
    logic       m_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] m_data;
    logic       m_sof, m_eol, m_valid, ovf_sticky, frame_done;
    logic [4:0] fifo_level;

    disparity_stream_postproc #(
        .ROW_LEN(ROW_LEN), .NUM_ROWS(NUM_ROWS), .FIFO_DEPTH(DEPTH), .HOLE_VAL(8'd0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .disp_in(disp_in), .disp_valid(disp_valid),
        .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol), .m_valid(m_valid),
        .m_ready(m_ready), .clr_ovf(clr_ovf), .ovf_sticky(ovf_sticky),
        .frame_done(frame_done), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] q[$];
    int fd_cnt = 0;

    // Record transferred words and frame_done pulses at the falling edge, where all signals are stable.
    always @(negedge clk) begin
        if (m_valid && m_ready) q.push_back({m_sof, m_eol, m_data});
        if (frame_done) fd_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(posedge clk); #1;
        disp_valid = 1'b1;
        disp_in    = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            disp_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        disp_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_level", fifo_level, 0);
        check("rst_valid", m_valid, 0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
        logic       sof;
        logic       eol;
    } vec_t;

    vec_t vecs[13];
    logic [9:0] w;

    initial begin
        // Full 4x3 frame followed by the first pixel of the next frame.
        vecs[0]  = '{8'd12, 8'd12, 1'b1, 1'b0};
        vecs[1]  = '{8'd0,  8'd12, 1'b0, 1'b0};
        vecs[2]  = '{8'd0,  8'd12, 1'b0, 1'b0};
        vecs[3]  = '{8'd30, 8'd30, 1'b0, 1'b1};
        vecs[4]  = '{8'd5,  8'd5,  1'b0, 1'b0};
        vecs[5]  = '{8'd8,  8'd8,  1'b0, 1'b0};
        vecs[6]  = '{8'd0,  8'd8,  1'b0, 1'b0};
        vecs[7]  = '{8'd9,  8'd9,  1'b0, 1'b1};
        vecs[8]  = '{8'd0,  8'd0,  1'b0, 1'b0};
        vecs[9]  = '{8'd0,  8'd0,  1'b0, 1'b0};
        vecs[10] = '{8'd7,  8'd7,  1'b0, 1'b0};
        vecs[11] = '{8'd0,  8'd7,  1'b0, 1'b1};
        vecs[12] = '{8'd3,  8'd3,  1'b1, 1'b0};

        // Values held during reset.
        repeat (2) @(negedge clk);
        check("reset_valid", m_valid, 0);
        check("reset_level", fifo_level, 0);
        check("reset_ovf", ovf_sticky, 0);
        check("reset_data", m_data, 0);
        check("reset_frame_done", frame_done, 0);
        rst_n = 1'b1;

        // Latency from a single sample to m_valid.
        m_ready = 1'b1;
        @(posedge clk); #1;
        disp_valid = 1'b1;
        disp_in    = 8'd42;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check("latency_not_yet", m_valid, 0);
            if (k == 0) begin
                @(posedge clk); #1;
                disp_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("latency_valid", m_valid, 1);
        check("latency_data", m_data, 42);
        check("latency_sof", m_sof, 1);

        // Move into the middle of the row, then reset.
        send(8'd1);
        send(8'd2);
        idle(4);
        do_reset();
        q = {};
        fd_cnt = 0;

`ifdef MEDIAN3_EN
        // Median: the isolated spike at col 1 passes because cols 0 and 1 are unfiltered.
        send(8'd5); send(8'd50); send(8'd5); send(8'd5);
        idle(8);
        check("med_count", q.size(), 4);
        if (q.size() == 4) begin
            check("med_w0", q[0][7:0], 5);
            check("med_w1", q[1][7:0], 50);
            check("med_w2", q[2][7:0], 5);
            check("med_w3", q[3][7:0], 5);
            check("med_sof", q[0][9], 1);
            check("med_eol", q[3][8], 1);
        end
        do_reset();
`else
        // Table: hole fill, row boundaries, sof/eol tags and frame_done over one frame.
        for (int i = 0; i < 13; i++) send(vecs[i].din);
        idle(6);
        check("table_count", q.size(), 13);
        check("frame_done_once", fd_cnt, 1);
        for (int i = 0; i < 13; i++) begin
            if (i < q.size()) begin
                w = q[i];
                check($sformatf("table_data_%0d", i), w[7:0], vecs[i].dout);
                check($sformatf("table_sof_%0d", i), w[9], vecs[i].sof);
                check($sformatf("table_eol_%0d", i), w[8], vecs[i].eol);
            end
        end
`endif

        // Overflow: 20 samples go into a 16-deep FIFO while the consumer is stalled.
        q = {};
        m_ready = 1'b0;
        for (int i = 1; i <= 20; i++) send(8'(i));
        idle(4);
        check("ovf_level", fifo_level, 16);
        check("ovf_set", ovf_sticky, 1);
        check("ovf_valid", m_valid, 1);
        m_ready = 1'b1;
        idle(20);
        check("ovf_drain_count", q.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < q.size()) check($sformatf("ovf_order_%0d", i), q[i][7:0], i + 1);
        check("ovf_sticky_held", ovf_sticky, 1);
        @(posedge clk); #1 clr_ovf = 1'b1;
        @(posedge clk); #1 clr_ovf = 1'b0;
        @(negedge clk);
        check("ovf_cleared", ovf_sticky, 0);

        // FIFO full, with a push and a pop in the same cycle.
        q = {};
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(101 + i));
        idle(4);
        check("full_level", fifo_level, 16);
        send(8'd117);
        @(posedge clk); #1;
        disp_valid = 1'b0;
        m_ready    = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        @(negedge clk);
        check("pushpop_level", fifo_level, 16);
        check("pushpop_no_ovf", ovf_sticky, 0);
        m_ready = 1'b1;
        idle(20);
        check("pushpop_count", q.size(), 17);
        if (q.size() == 17) begin
            check("pushpop_first", q[0][7:0], 101);
            check("pushpop_last", q[16][7:0], 117);
        end
        check("final_empty", fifo_level, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
